seq_detect_ctrl: RTL and testbench

Programmable serial pattern-detect controller. It takes a runtime pattern, length and target match count over a ready/valid config port, then arms on start. While armed it scans a qualified serial bit stream for the pattern, with overlapping matches allowed. It ends a run after N matches, on abort, or on timeout. It sits between the control/CSR side and the serial input path, and generalises the fixed 0110 detector into a sequenced, reusable engine.

---
 rtl/seq_detect_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl -- programmable serial pattern-detect controller.
//
// Takes a runtime pattern, length and match target over a ready/valid config
// port, arms on start, then scans the qualified serial stream for the pattern.
// Overlapping matches are allowed. A run ends after the target number of
// matches, on abort, or (optional) on timeout.
//
// Optional feature macro: SEQ_TIMEOUT_EN
//   defined   -> an armed run with TIMEOUT_CYC cycles between matches (or
//                since arm) ends with a one-cycle timeout pulse.
//   undefined -> no timeout counter, timeout is held at 0.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   in           serial data bit
//   in_valid     in is sampled only when high
//   cfg_valid    config offer
//   cfg_ready    config acceptance, high only in IDLE
//   cfg_pattern  pattern; bit [len-1] is received first, bit 0 last
//   cfg_len      pattern length 1..PAT_W (0 or >PAT_W stored as PAT_W)
//   cfg_target   matches per run, 0 = continuous
//   start        arm request (needs a loaded config)
//   abort        cancel the run
//   busy         high while ARMED
//   out          one-cycle match pulse
//   done         one-cycle pulse when the target is reached
//   timeout      one-cycle timeout pulse
//   match_count  matches in the current or last run (saturating)

module seq_detect_ctrl #(
    parameter int PAT_W       = 8,
    parameter int LEN_W       = 4,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             out,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] match_count
);

    // Elaboration-time sanity on the parameter set.
    if ((PAT_W < 2) || ((1 << LEN_W) <= PAT_W) || (TIMEOUT_CYC < 2)) begin : g_bad_params
        $error("seq_detect_ctrl: PAT_W>=2, LEN_W must hold PAT_W, TIMEOUT_CYC>=2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] target;
    logic             cfg_loaded;
    logic [PAT_W-1:0] sr;
    logic [LEN_W-1:0] fill;

`ifdef SEQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] tcnt;
`endif

    logic [PAT_W-1:0] sr_next;
    logic [LEN_W-1:0] fill_next;
    logic [LEN_W-1:0] cfg_len_norm;
    logic [CNT_W-1:0] count_inc;
    logic             bit_match;

    // Mask selecting the low n bits of a pattern-wide word.
    function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] n);
        logic [PAT_W-1:0] m;
        for (int i = 0; i < PAT_W; i++) begin
            m[i] = (i < int'(n));
        end
        return m;
    endfunction

    always_comb begin
        sr_next      = {sr[PAT_W-2:0], in};
        fill_next    = (fill == LEN_W'(PAT_W)) ? fill : fill + 1'b1;
        cfg_len_norm = ((cfg_len == '0) || (cfg_len > LEN_W'(PAT_W))) ? LEN_W'(PAT_W) : cfg_len;
        count_inc    = (&match_count) ? match_count : match_count + 1'b1;
        // Match is judged on the post-shift window so the pulse belongs to
        // the edge that samples the final pattern bit.
        bit_match    = in_valid && (fill_next >= len) &&
                       (((sr_next ^ pat) & len_mask(len)) == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cfg_ready   <= 1'b1;
            busy        <= 1'b0;
            out         <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            match_count <= '0;
            cfg_loaded  <= 1'b0;
            sr          <= '0;
            fill        <= '0;
`ifdef SEQ_TIMEOUT_EN
            tcnt        <= '0;
`endif
        end else begin
            out     <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        pat        <= cfg_pattern;
                        len        <= cfg_len_norm;
                        target     <= cfg_target;
                        cfg_loaded <= 1'b1;
                    end
                    // A config offered on the same edge counts as loaded.
                    if (start && (cfg_loaded || (cfg_valid && cfg_ready))) begin
                        state       <= S_ARMED;
                        busy        <= 1'b1;
                        cfg_ready   <= 1'b0;
                        sr          <= '0;
                        fill        <= '0;
                        match_count <= '0;
`ifdef SEQ_TIMEOUT_EN
                        tcnt        <= '0;
`endif
                    end
                end

                S_ARMED: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end else begin
                        if (in_valid) begin
                            sr   <= sr_next;
                            fill <= fill_next;
                        end
                        if (bit_match) begin
                            // Window is kept so overlapping matches count.
                            out         <= 1'b1;
                            match_count <= count_inc;
`ifdef SEQ_TIMEOUT_EN
                            tcnt        <= '0;
`endif
                            if ((target != '0) && (count_inc == target)) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
`ifdef SEQ_TIMEOUT_EN
                        else if (tcnt == TO_LAST) begin
                            timeout   <= 1'b1;
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            cfg_ready <= 1'b1;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
`endif
                    end
                end

                S_DONE: begin
                    state     <= S_IDLE;
                    cfg_ready <= 1'b1;
                end

                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: a queue-based reference model is
// compared against the DUT every cycle, and directed scenarios pin the
// model with hand-computed pulse positions and counts.

module tb_seq_detect_ctrl;
  localparam int PAT_W  = 8;
  localparam int LEN_W  = 4;
  localparam int CNT_W  = 8;
  localparam int TO_CYC = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in = 1'b0, in_valid = 1'b0, cfg_valid = 1'b0, start = 1'b0, abort = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [CNT_W-1:0] cfg_target = '0;
  logic cfg_ready, busy, out, done, timeout;
  logic [CNT_W-1:0] match_count;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_target(cfg_target), .start(start), .abort(abort),
    .busy(busy), .out(out), .done(done), .timeout(timeout), .match_count(match_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_ARMED, M_DONE} mphase_t;
  mphase_t ph = M_IDLE;
  bit loaded = 1'b0;
  bit [PAT_W-1:0] m_pat;
  int m_len, m_tgt;
  bit hist[$];          // every bit accepted since arm, oldest first
  int e_cnt = 0;
  int since = 0;
  bit e_out = 0, e_done = 0, e_to = 0;
  bit hit;

  always @(posedge clk) begin
    if (reset) begin
      ph = M_IDLE; loaded = 0; e_out = 0; e_done = 0; e_to = 0; e_cnt = 0;
      hist.delete();
    end else begin
      e_out = 0; e_done = 0; e_to = 0;
      case (ph)
        M_IDLE: begin
          if (cfg_valid) begin
            m_pat  = cfg_pattern;
            m_len  = (cfg_len == 0 || cfg_len > PAT_W) ? PAT_W : int'(cfg_len);
            m_tgt  = int'(cfg_target);
            loaded = 1;
          end
          if (start && loaded) begin
            ph = M_ARMED; hist.delete(); e_cnt = 0; since = 0;
          end
        end
        M_ARMED: begin
          if (abort) ph = M_IDLE;
          else begin
            hit = 0;
            if (in_valid) begin
              hist.push_back(in);
              if (hist.size() >= m_len) begin
                hit = 1;
                for (int i = 0; i < m_len; i++)
                  if (hist[hist.size()-1-i] != m_pat[i]) hit = 0;
              end
            end
            if (hit) begin
              e_out = 1;
              if (e_cnt < (1 << CNT_W) - 1) e_cnt++;
              since = 0;
              if (m_tgt != 0 && e_cnt == m_tgt) begin ph = M_DONE; e_done = 1; end
            end
`ifdef SEQ_TIMEOUT_EN
            else if (since == TO_CYC - 1) begin e_to = 1; ph = M_IDLE; end
            else since++;
`endif
          end
        end
        M_DONE: ph = M_IDLE;
        default: ph = M_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  int pulse_at[$];      // bit index (since arm) of each observed out pulse
  int done_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out", int'(out), int'(e_out));
      chk("done", int'(done), int'(e_done));
      chk("timeout", int'(timeout), int'(e_to));
      chk("busy", int'(busy), int'(ph == M_ARMED));
      chk("cfg_ready", int'(cfg_ready), int'(ph == M_IDLE));
      chk("match_count", int'(match_count), e_cnt);
      if (out) pulse_at.push_back(hist.size());
      if (done) done_cnt++;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg_start(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                           input logic [CNT_W-1:0] t);
    cfg_pattern = p; cfg_len = l; cfg_target = t;
    cfg_valid = 1; start = 1;
    pulse_at.delete(); done_cnt = 0;
    tick();
    cfg_valid = 0; start = 0;
  endtask

  task automatic feed(input bit b, input int stalls);
    in = b; in_valid = 1;
    tick();
    in_valid = 0; in = ~b;
    repeat (stalls) tick();
  endtask

  task automatic do_abort();
    abort = 1; tick(); abort = 0;
  endtask

  bit s1 [20] = '{1,0,1,1,0,1,0,1,1,0,0,0,1,0,0,1,1,0,0,1};
  bit s2 [5]  = '{1,0,1,0,1};
  bit s3 [12] = '{0,0,1,1,1,0,1,1,0,0,1,1};
  int first_to;

  initial begin
    @(posedge clk); #1;
    chk_en = 1;
    tick();
    reset = 0;
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(match_count), 0);
    chk("rst_out", int'(out), 0);

    // start with no config loaded is ignored
    start = 1; tick(); start = 0; tick();
    chk("nocfg_busy", int'(busy), 0);

    // Scenario 1: 0110 continuous
    cfg_start(8'b0110, 4'd4, 8'd0);
    chk("s1_busy", int'(busy), 1);
    foreach (s1[i]) feed(s1[i], 0);
    do_abort();
    chk("s1_np", pulse_at.size(), 3);
    chk("s1_p0", pulse_at[0], 5);
    chk("s1_p1", pulse_at[1], 10);
    chk("s1_p2", pulse_at[2], 18);
    chk("s1_count", int'(match_count), 3);
    chk("s1_done", done_cnt, 0);

    // Scenario 2: overlap 101, target 2
    cfg_start(8'b101, 4'd3, 8'd2);
    foreach (s2[i]) feed(s2[i], 0);
    tick();
    chk("s2_np", pulse_at.size(), 2);
    chk("s2_p0", pulse_at[0], 3);
    chk("s2_p1", pulse_at[1], 5);
    chk("s2_done", done_cnt, 1);
    chk("s2_count", int'(match_count), 2);
    chk("s2_busy", int'(busy), 0);
    chk("s2_ready", int'(cfg_ready), 1);

    // Scenario 3: scenario 1 with two stall cycles between bits
    cfg_start(8'b0110, 4'd4, 8'd0);
    foreach (s1[i]) feed(s1[i], (i == 19) ? 0 : 2);
    do_abort();
`ifndef SEQ_TIMEOUT_EN
    chk("s3_np", pulse_at.size(), 3);
    chk("s3_p0", pulse_at[0], 5);
    chk("s3_p1", pulse_at[1], 10);
    chk("s3_p2", pulse_at[2], 18);
    chk("s3_count", int'(match_count), 3);
`endif

    // Scenario 4: abort on the completing 4th bit, then re-arm with old config
    cfg_start(8'b0110, 4'd4, 8'd0);
    feed(0, 0); feed(1, 0); feed(1, 0);
    abort = 1; feed(0, 0); abort = 0;
    chk("s4_out", int'(out), 0);
    chk("s4_busy", int'(busy), 0);
    chk("s4_ready", int'(cfg_ready), 1);
    chk("s4_count", int'(match_count), 0);
    chk("s4_np", pulse_at.size(), 0);
    chk("s4_done", done_cnt, 0);
    start = 1; tick(); start = 0;
    chk("s4_rearm", int'(busy), 1);
    feed(0, 0); feed(1, 0); feed(1, 0); feed(0, 0);
    tick();
    chk("s4_np2", pulse_at.size(), 1);
    chk("s4_p0", pulse_at[0], 4);
    chk("s4_count2", int'(match_count), 1);
    do_abort();

    // Scenario 5: reset mid-run discards config; then len=0 acts as len=8
    cfg_start(8'b0110, 4'd4, 8'd0);
    feed(0, 0); feed(1, 0);
    reset = 1; tick(); reset = 0;
    chk("s5_busy", int'(busy), 0);
    chk("s5_count", int'(match_count), 0);
    start = 1; tick(); start = 0; tick();
    chk("s5_nostart", int'(busy), 0);
    chk("s5_ready", int'(cfg_ready), 1);
    cfg_start(8'b10110011, 4'd0, 8'd1);
    foreach (s3[i]) feed(s3[i], 0);
    tick();
    chk("s5_np", pulse_at.size(), 1);
    chk("s5_p0", pulse_at[0], 12);
    chk("s5_done", done_cnt, 1);
    chk("s5_count2", int'(match_count), 1);
    chk("s5_busy2", int'(busy), 0);

`ifdef SEQ_TIMEOUT_EN
    // Scenario 6: all zeros against 0110 -> timeout 16 cycles after arm
    cfg_start(8'b0110, 4'd4, 8'd0);
    in = 0; in_valid = 1;
    first_to = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (timeout && first_to < 0) first_to = k;
    end
    in_valid = 0;
    chk("s6_to_at", first_to, TO_CYC);
    chk("s6_done", done_cnt, 0);
    chk("s6_busy", int'(busy), 0);
`endif

    tick();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
